// File: rtl/ssd_scan_ctrl_if.sv
// Write-side bus from the keypad/menu FSM into ssd_scan_ctrl.
// Handshake: no ready; every cycle with wr_en=1 is one accepted character, clr=1 wins over wr_en.
interface ssd_scan_ctrl_if;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [2:0] wr_col;
  logic       wr_alpha;
  logic       wr_r_c;
  logic       clr;

  modport master (output wr_en, wr_row, wr_col, wr_alpha, wr_r_c, clr);
  modport slave  (input  wr_en, wr_row, wr_col, wr_alpha, wr_r_c, clr);
endinterface

// File: rtl/ssd_scan_ctrl.sv
// N-digit calculator-style 7-segment buffer with time-multiplexed scan output.
// Optional cursor blink on slot 0 is enabled by defining SSD_SCAN_BLINK_EN.
module ssd_scan_ctrl #(
  parameter int N_DIGITS = 4,
  parameter int CLK_DIV  = 50000
`ifdef SSD_SCAN_BLINK_EN
  , parameter int BLINK_DIV = 256
`endif
) (
  input  logic                            clk,
  input  logic                            rst,
  ssd_scan_ctrl_if.slave                  wr,
  output logic [N_DIGITS-1:0]             an,
  output logic [6:0]                      ssd,
  output logic [$clog2(N_DIGITS+1)-1:0]   count,
  output logic                            full
);

  localparam int PSC_W = $clog2(CLK_DIV);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int CNT_W = $clog2(N_DIGITS+1);
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b1111110;
  localparam logic [N_DIGITS-1:0] AN_ONE = {{(N_DIGITS-1){1'b0}}, 1'b1};

  function automatic logic [6:0] decode(input logic alpha, input logic r_c,
                                        input logic [2:0] row, input logic [2:0] col);
    logic [6:0] pat;
    logic [2:0] digit;
    pat   = DASH;
    digit = r_c ? row : col;
    if (alpha) begin
      // Octal literal digits are {row, col}.
      case ({row, col})
        6'o11: pat = 7'b0001000;
        6'o12: pat = 7'b1100000;
        6'o13: pat = 7'b0110001;
        6'o14: pat = 7'b1000010;
        6'o15: pat = 7'b0110000;
        6'o21: pat = 7'b0111000;
        6'o22: pat = 7'b0100000;
        6'o23: pat = 7'b1001000;
        6'o24: pat = 7'b1001111;
        6'o32: pat = 7'b1110001;
        6'o34: pat = 7'b1101010;
        6'o35: pat = 7'b0000001;
        6'o41: pat = 7'b0011000;
        6'o43: pat = 7'b1111010;
        6'o44: pat = 7'b0100100;
        6'o45: pat = 7'b1110000;
        default: pat = DASH;
      endcase
    end else begin
      case (digit)
        3'd1: pat = 7'b1001111;
        3'd2: pat = 7'b0010010;
        3'd3: pat = 7'b0000110;
        3'd4: pat = 7'b1001100;
        3'd5: pat = 7'b0100100;
        default: pat = DASH;
      endcase
    end
    return pat;
  endfunction

  logic [PSC_W-1:0]             psc_q, psc_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [N_DIGITS-1:0][6:0]     slot_q, slot_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic                         full_q, full_d;
  logic [N_DIGITS-1:0]          an_q, an_d;
  logic [6:0]                   ssd_q, ssd_d;
  logic                         tick;

`ifdef SSD_SCAN_BLINK_EN
  localparam int BCNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic              blink_q, blink_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
`endif

  always_comb begin
    tick  = (psc_q == PSC_W'(CLK_DIV-1));
    psc_d = tick ? '0 : psc_q + PSC_W'(1);
    idx_d = idx_q;
    if (tick) idx_d = (idx_q == IDX_W'(N_DIGITS-1)) ? '0 : idx_q + IDX_W'(1);

    slot_d  = slot_q;
    count_d = count_q;
    if (wr.clr) begin
      slot_d  = {N_DIGITS{BLANK}};
      count_d = '0;
    end else if (wr.wr_en) begin
      slot_d  = {slot_q[N_DIGITS-2:0], decode(wr.wr_alpha, wr.wr_r_c, wr.wr_row, wr.wr_col)};
      if (count_q != CNT_W'(N_DIGITS)) count_d = count_q + CNT_W'(1);
    end
    full_d = (count_d == CNT_W'(N_DIGITS));

    // Pins follow the current index/buffer one cycle later.
    an_d  = ~(AN_ONE << idx_q);
    ssd_d = slot_q[idx_q];

`ifdef SSD_SCAN_BLINK_EN
    blink_d = blink_q;
    bcnt_d  = bcnt_q;
    if (wr.clr || wr.wr_en) begin
      blink_d = 1'b1;
      bcnt_d  = '0;
    end else if (tick) begin
      if (bcnt_q == BCNT_W'(BLINK_DIV-1)) begin
        bcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d = bcnt_q + BCNT_W'(1);
      end
    end
    if (!blink_q && (count_q != '0) && (idx_q == '0)) ssd_d = BLANK;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q   <= '0;
      idx_q   <= '0;
      slot_q  <= {N_DIGITS{BLANK}};
      count_q <= '0;
      full_q  <= 1'b0;
      an_q    <= '1;
      ssd_q   <= BLANK;
`ifdef SSD_SCAN_BLINK_EN
      blink_q <= 1'b1;
      bcnt_q  <= '0;
`endif
    end else begin
      psc_q   <= psc_d;
      idx_q   <= idx_d;
      slot_q  <= slot_d;
      count_q <= count_d;
      full_q  <= full_d;
      an_q    <= an_d;
      ssd_q   <= ssd_d;
`ifdef SSD_SCAN_BLINK_EN
      blink_q <= blink_d;
      bcnt_q  <= bcnt_d;
`endif
    end
  end

  assign an    = an_q;
  assign ssd   = ssd_q;
  assign count = count_q;
  assign full  = full_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: per-cycle expected pins from a queue-based model, checked by a monitor.
module tb_ssd_scan_ctrl;
  localparam int N       = 4;
  localparam int CLK_DIV = 4;
  localparam int CW      = $clog2(N+1);
  localparam int W       = N + 7 + CW + 1;
`ifdef SSD_SCAN_BLINK_EN
  localparam int BLINK_DIV = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  an;
  logic [6:0]    ssd;
  logic [CW-1:0] count;
  logic          full;

  ssd_scan_ctrl_if wr_if ();

  ssd_scan_ctrl #(
    .N_DIGITS(N),
    .CLK_DIV (CLK_DIV)
`ifdef SSD_SCAN_BLINK_EN
    , .BLINK_DIV(BLINK_DIV)
`endif
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .wr   (wr_if),
    .an   (an),
    .ssd  (ssd),
    .count(count),
    .full (full)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  logic [6:0]   disp_q[$];   // characters held, newest first
  int           edges;       // clock edges since reset release
  int           ticks_since; // scan ticks since last write/clr/reset
  int           tests;
  int           fails;

  function automatic logic [6:0] ref_decode(input int row, input int col,
                                            input bit alpha, input bit r_c);
    int d;
    if (alpha) begin
      case (row * 10 + col)
        11: return 7'b0001000;
        12: return 7'b1100000;
        13: return 7'b0110001;
        14: return 7'b1000010;
        15: return 7'b0110000;
        21: return 7'b0111000;
        22: return 7'b0100000;
        23: return 7'b1001000;
        24: return 7'b1001111;
        32: return 7'b1110001;
        34: return 7'b1101010;
        35: return 7'b0000001;
        41: return 7'b0011000;
        43: return 7'b1111010;
        44: return 7'b0100100;
        45: return 7'b1110000;
        default: return 7'b1111110;
      endcase
    end
    d = r_c ? row : col;
    case (d)
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      default: return 7'b1111110;
    endcase
  endfunction

  // Driver tasks
  task automatic drive(input bit we, input int row, input int col,
                       input bit alpha, input bit r_c, input bit cl);
    wr_if.wr_en    = we;
    wr_if.wr_row   = 3'(row);
    wr_if.wr_col   = 3'(col);
    wr_if.wr_alpha = alpha;
    wr_if.wr_r_c   = r_c;
    wr_if.clr      = cl;
  endtask

  task automatic step(input bit we, input int row, input int col,
                      input bit alpha, input bit r_c, input bit cl);
    int            idx;
    logic [N-1:0]  one;
    logic [N-1:0]  e_an;
    logic [6:0]    shown;
    logic [CW-1:0] e_cnt;
    logic          e_full;
    drive(we, row, col, alpha, r_c, cl);
    one   = 1;
    idx   = (edges / CLK_DIV) % N;
    e_an  = ~(one << idx);
    shown = (idx < disp_q.size()) ? disp_q[idx] : 7'h7F;
`ifdef SSD_SCAN_BLINK_EN
    if (idx == 0 && disp_q.size() > 0 && ((ticks_since / BLINK_DIV) % 2) == 1) shown = 7'h7F;
    if (cl || we) ticks_since = 0;
    else if ((edges + 1) % CLK_DIV == 0) ticks_since++;
`endif
    if (cl) disp_q.delete();
    else if (we) begin
      disp_q.push_front(ref_decode(row, col, alpha, r_c));
      if (disp_q.size() > N) void'(disp_q.pop_back());
    end
    e_cnt  = CW'(disp_q.size());
    e_full = (disp_q.size() == N);
    @(posedge clk);
    exp_q.push_back({e_an, shown, e_cnt, e_full});
    edges++;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    repeat (n) begin
      @(posedge clk);
      exp_q.push_back({{N{1'b1}}, 7'h7F, CW'(0), 1'b0});
      #1;
    end
    rst = 1'b0;
    disp_q.delete();
    edges       = 0;
    ticks_since = 0;
  endtask

  // Monitor: one expected pin set per clock edge, checked mid-cycle
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests++;
        if ({an, ssd, count, full} !== e) begin
          fails++;
          $display("FAIL pins t=%0t: got an=%b ssd=%b count=%0d full=%b, want an=%b ssd=%b count=%0d full=%b",
                   $time, an, ssd, count, full, e[W-1 -: N], e[W-N-1 -: 7], e[CW:1], e[0]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    tests       = 0;
    fails       = 0;
    edges       = 0;
    ticks_since = 0;
    drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    do_reset(3);
    idle(20);

    // A, numeric col 3, n
    step(1'b1, 1, 1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 0, 3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3, 4, 1'b1, 1'b0, 1'b0);
    idle(20);

    // Overfill with digits 1..5 via row source
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    for (int d = 1; d <= 5; d++) step(1'b1, d, 0, 1'b0, 1'b1, 1'b0);
    idle(20);

    // clr colliding with a write, then an invalid code
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 2, 2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4, 1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1, 1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 6, 6, 1'b1, 1'b0, 1'b0);
    idle(20);

    // Reset in the middle of activity
    step(1'b1, 4, 4, 1'b1, 1'b0, 1'b0);
    do_reset(2);
    idle(8);

    // Randomized traffic with occasional long idle gaps
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) == 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0);
      if ($urandom_range(0, 9) == 0) idle(int'($urandom_range(8, 40)));
    end
    idle(12);

    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
